midi_rx_decoder: RTL and testbench
==================================

// Module: midi_rx_decoder
// PURPOSE
//  Receives the raw 31250-baud MIDI serial line and assembles complete channel-voice messages.
//  Presents each message as status/data1/data2 with a one-cycle midi_byte_ready strobe.
//  Sits directly upstream of midi_controller, which consumes midi_byte0/1/2 on that strobe.
//  Handles running status, realtime bytes, system/sysex skipping, and framing errors.
// PARAMETERS
//  CLK_FREQ    50_000_000  system clock frequency, Hz
//  BAUD        31250       MIDI line rate, bits/s
//  OVERSAMPLE  16          receiver sample ticks per bit; CLK_FREQ/(BAUD*OVERSAMPLE) must be an integer >= 2
// PORTS
//  clk              in   1  system clock; single clock domain
//  reset            in   1  asynchronous, active-low reset
//  midi_rx          in   1  raw serial MIDI input; idle high; asynchronous to clk
//  midi_byte_ready  out  1  one-cycle pulse: a complete message is valid on midi_byte0..2
//  midi_byte0       out  8  status byte (0x80..0xEF)
//  midi_byte1       out  8  first data byte
//  midi_byte2       out  8  second data byte; 0x00 for 1-data-byte messages (0xC_, 0xD_)
//  framing_error    out  1  one-cycle pulse: stop bit sampled low, byte discarded
// BEHAVIOUR
//  Reset: all outputs 0; running status cleared; parser in IDLE; receiver in WAIT_START.
//   Reset asserted mid-byte or mid-message discards all partial state.
//  Receiver:
//   - midi_rx passes a 2-flop synchronizer; the line is treated as 1 while the synchronizer is in reset.
//   - Baud tick divider = CLK_FREQ/(BAUD*OVERSAMPLE).
//   - Falling edge -> START. Line is resampled at tick OVERSAMPLE/2; if high, false start -> WAIT_START.
//   - 8 data bits sampled mid-bit, LSB first. Stop bit sampled mid-bit.
//   - Stop bit high -> byte_valid pulse. Stop bit low -> framing_error pulse, byte dropped, parser state unchanged.
//  Parser (states IDLE, DATA1, DATA2, SKIP); rs = running-status register:
//   - 0xF8..0xFF realtime: ignored completely; state, rs and partial data are untouched.
//   - 0x80..0xEF status: rs <= byte; need = 1 for 0xC_/0xD_, else 2; -> DATA1.
//     A status arriving in DATA1 or DATA2 aborts the partial message without emitting a strobe.
//   - 0xF0..0xF7 system common/sysex: rs cleared; -> SKIP. SKIP drops data bytes until the next
//     0x80..0xEF status byte.
//   - Data byte (< 0x80) handling:
//     - IDLE with rs != 0: treated as data1 (running status).
//     - IDLE with rs == 0: dropped.
//     - DATA1: store data1; if need == 1, emit, else -> DATA2.
//     - DATA2: store data2, emit.
//   - Emit: midi_byte0 <= rs, midi_byte1 <= d1, midi_byte2 <= d2 (or 0x00); midi_byte_ready = 1
//     for exactly one cycle; -> IDLE with rs retained.
//  Latency: midi_byte_ready asserts 1 clk after the stop-bit sample of the final byte.
//  midi_byte0..2 are registered and hold their value until the next emit. The controller may
//   sample them any number of cycles after the strobe.
//  Velocity-0 note-ons are passed through unchanged; note-off interpretation belongs downstream.
//  Minimum spacing between strobes is one MIDI byte time (~320 us), so no output queue is needed.
// STRUCTURE
//  midi_pkg shared package:
//   - status-class constants (NOTE_OFF=4'h8, NOTE_ON=4'h9, PROG_CHG=4'hC, CHAN_PRESS=4'hD, SYS=4'hF)
//   - REALTIME_MIN=8'hF8
//   - function data_len(status) -> 1 or 2
//  Sub-module midi_uart_rx: synchronizer, baud divider and bit FSM.
//   Outputs rx_byte[7:0], rx_valid and framing_error.
//  Parser FSM lives in midi_rx_decoder.
// TESTING
//  1. Serial 0x90,0x3C,0x64 -> one strobe with byte0=90, byte1=3C, byte2=64; strobe 1 clk after last stop sample.
//  2. Running status: 0x90,0x3C,0x64 then 0x3E,0x00 -> second strobe 90/3E/00; 2 strobes total.
//  3. 0xC0,0x05 -> strobe C0/05/00.
//     Then 0xF0,0x7E,0x01,0xF7,0x40 -> no strobe (rs cleared, 0x40 dropped).
//  4. 0xF8 inserted between 0x90 and 0x3C, and 0xFE inserted between 0x3C and 0x64
//     -> single strobe 90/3C/64, identical to test 1.
//  5. Byte with stop bit forced low during 0x3C -> framing_error pulse.
//     Resending 0x3C,0x64 -> strobe 90/3C/64.
//     A 0.25-bit low glitch on idle line -> no byte, no error.
//  6. Reset asserted mid-data-byte after 0x90 -> outputs 0.
//     After release, 0x3C,0x64 -> no strobe (rs cleared).
//     Then 0x80,0x3C,0x40 -> strobe 80/3C/40.

Source files
------------

// File: rtl/midi_pkg.sv
// rtl/midi_pkg.sv - shared MIDI constants, state types and message-length helper
// Purpose: status-class constants, realtime threshold, receiver/parser state
//          encodings and data_len() used by midi_uart_rx and midi_rx_decoder.
package midi_pkg;

    localparam logic [3:0] NOTE_OFF   = 4'h8;
    localparam logic [3:0] NOTE_ON    = 4'h9;
    localparam logic [3:0] PROG_CHG   = 4'hC;
    localparam logic [3:0] CHAN_PRESS = 4'hD;
    localparam logic [3:0] SYS        = 4'hF;

    localparam logic [7:0] REALTIME_MIN = 8'hF8;

    typedef enum logic [1:0] {
        RX_WAIT_START,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        P_IDLE,
        P_DATA1,
        P_DATA2,
        P_SKIP
    } parse_state_t;

    // Number of data bytes that follow a channel-voice status byte.
    function automatic logic [1:0] data_len(input logic [7:0] status);
        if (status[7:4] == PROG_CHG || status[7:4] == CHAN_PRESS)
            return 2'd1;
        else
            return 2'd2;
    endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// rtl/midi_uart_rx.sv - oversampling 8N1 serial receiver for the MIDI line
// Purpose: synchronizes midi_rx, divides clk down to OVERSAMPLE ticks per bit,
//          and frames start/8 data (LSB first)/stop bits.
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous active-low reset
//   midi_rx       in   raw serial input, idle high, asynchronous to clk
//   rx_byte       out  last received byte (valid while rx_valid is high)
//   rx_valid      out  one-cycle pulse, byte received with a good stop bit
//   framing_error out  one-cycle pulse, stop bit sampled low, byte dropped
module midi_uart_rx
    import midi_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 31250,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       midi_rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       framing_error
);

    localparam int DIV  = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW   = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int HALF = OVERSAMPLE / 2;

    rx_state_t       r_state;
    logic [1:0]      r_sync;
    logic            r_prev;
    logic [DW-1:0]   r_div;
    logic [TW-1:0]   r_tick_cnt;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;

    logic            w_rx;
    logic            w_tick;
    logic            w_half;
    logic            w_full;

    assign w_rx    = r_sync[1];
    assign w_tick  = (r_div == DW'(DIV - 1));
    assign w_half  = (r_tick_cnt == TW'(HALF - 1));
    assign w_full  = (r_tick_cnt == TW'(OVERSAMPLE - 1));
    assign rx_byte = r_shift;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= RX_WAIT_START;
            r_sync        <= 2'b11;   // line reads idle while in reset
            r_prev        <= 1'b1;
            r_div         <= '0;
            r_tick_cnt    <= '0;
            r_bit         <= '0;
            r_shift       <= '0;
            rx_valid      <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            r_sync        <= {r_sync[0], midi_rx};
            r_prev        <= w_rx;
            rx_valid      <= 1'b0;
            framing_error <= 1'b0;

            // Divider only runs inside a frame so every frame is phase-aligned
            // to its own start edge.
            if (r_state == RX_WAIT_START || w_tick)
                r_div <= '0;
            else
                r_div <= r_div + 1'b1;

            case (r_state)
                RX_WAIT_START: begin
                    r_tick_cnt <= '0;
                    if (r_prev && !w_rx)
                        r_state <= RX_START;
                end
                RX_START: begin
                    if (w_tick) begin
                        if (w_half) begin
                            r_tick_cnt <= '0;
                            r_bit      <= '0;
                            // Still low at mid-start: genuine start bit.
                            r_state    <= w_rx ? RX_WAIT_START : RX_DATA;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                RX_DATA: begin
                    if (w_tick) begin
                        if (w_full) begin
                            r_tick_cnt <= '0;
                            r_shift    <= {w_rx, r_shift[7:1]};
                            r_bit      <= r_bit + 1'b1;
                            if (r_bit == 3'd7)
                                r_state <= RX_STOP;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                RX_STOP: begin
                    if (w_tick) begin
                        if (w_full) begin
                            r_tick_cnt <= '0;
                            if (w_rx)
                                rx_valid <= 1'b1;
                            else
                                framing_error <= 1'b1;
                            r_state <= RX_WAIT_START;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= RX_WAIT_START;
            endcase
        end
    end

endmodule

// File: rtl/midi_rx_decoder.sv
// rtl/midi_rx_decoder.sv - MIDI serial receiver and channel-voice message parser
// Purpose: assembles complete channel-voice messages (with running status,
//          realtime pass-over and system/sysex skipping) from the MIDI line.
// Ports:
//   clk              in   system clock
//   reset            in   asynchronous active-low reset
//   midi_rx          in   raw serial MIDI input, idle high
//   midi_byte_ready  out  one-cycle pulse, message valid on midi_byte0..2
//   midi_byte0       out  status byte
//   midi_byte1       out  first data byte
//   midi_byte2       out  second data byte, 0x00 for one-data-byte messages
//   framing_error    out  one-cycle pulse, byte with a low stop bit dropped
module midi_rx_decoder
    import midi_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 31250,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       midi_rx,
    output logic       midi_byte_ready,
    output logic [7:0] midi_byte0,
    output logic [7:0] midi_byte1,
    output logic [7:0] midi_byte2,
    output logic       framing_error
);

    logic [7:0]   w_rx_byte;
    logic         w_rx_valid;

    parse_state_t r_state;
    logic [7:0]   r_rs;
    logic [7:0]   r_d1;
    logic         r_need_one;

    midi_uart_rx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_uart_rx (
        .clk           (clk),
        .reset         (reset),
        .midi_rx       (midi_rx),
        .rx_byte       (w_rx_byte),
        .rx_valid      (w_rx_valid),
        .framing_error (framing_error)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= P_IDLE;
            r_rs            <= '0;
            r_d1            <= '0;
            r_need_one      <= 1'b0;
            midi_byte_ready <= 1'b0;
            midi_byte0      <= '0;
            midi_byte1      <= '0;
            midi_byte2      <= '0;
        end else begin
            midi_byte_ready <= 1'b0;
            if (w_rx_valid) begin
                if (w_rx_byte >= REALTIME_MIN) begin
                    // Realtime bytes may interleave anywhere; leave everything as is.
                end else if (w_rx_byte[7:4] == SYS) begin
                    r_rs    <= '0;
                    r_state <= P_SKIP;
                end else if (w_rx_byte[7]) begin
                    // New status also abandons any partially collected message.
                    r_rs       <= w_rx_byte;
                    r_need_one <= (data_len(w_rx_byte) == 2'd1);
                    r_state    <= P_DATA1;
                end else begin
                    case (r_state)
                        P_IDLE, P_DATA1: begin
                            // In IDLE a nonzero rs means running status.
                            if (r_rs != 8'h00) begin
                                if (r_need_one) begin
                                    midi_byte0      <= r_rs;
                                    midi_byte1      <= w_rx_byte;
                                    midi_byte2      <= 8'h00;
                                    midi_byte_ready <= 1'b1;
                                    r_state         <= P_IDLE;
                                end else begin
                                    r_d1    <= w_rx_byte;
                                    r_state <= P_DATA2;
                                end
                            end
                        end
                        P_DATA2: begin
                            midi_byte0      <= r_rs;
                            midi_byte1      <= r_d1;
                            midi_byte2      <= w_rx_byte;
                            midi_byte_ready <= 1'b1;
                            r_state         <= P_IDLE;
                        end
                        P_SKIP: begin
                        end
                        default: r_state <= P_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_midi_rx_decoder.sv
// tb/tb_midi_rx_decoder.sv - self-checking bench for midi_rx_decoder
module tb_midi_rx_decoder;

    localparam int BIT_CLKS = 32;   // 1 MHz / 31250 baud
    localparam int LATENCY  = 308;  // start-bit drive to strobe visible, in posedges

    logic       clk = 1'b0;
    logic       reset;
    logic       midi_rx;
    logic       midi_byte_ready;
    logic [7:0] midi_byte0;
    logic [7:0] midi_byte1;
    logic [7:0] midi_byte2;
    logic       framing_error;

    int cyc = 0;
    int n_strobe = 0;
    int n_fe = 0;
    int last_strobe_cyc = 0;
    int start_cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    midi_rx_decoder #(
        .CLK_FREQ   (1_000_000),
        .BAUD       (31250),
        .OVERSAMPLE (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .midi_rx         (midi_rx),
        .midi_byte_ready (midi_byte_ready),
        .midi_byte0      (midi_byte0),
        .midi_byte1      (midi_byte1),
        .midi_byte2      (midi_byte2),
        .framing_error   (framing_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (midi_byte_ready) begin
            n_strobe        = n_strobe + 1;
            last_strobe_cyc = cyc;
        end
        if (framing_error)
            n_fe = n_fe + 1;
    end

    typedef struct {
        logic [0:5][7:0] seq;
        int              n;
        int              strobes;
        logic [7:0]      e0;
        logic [7:0]      e1;
        logic [7:0]      e2;
    } vec_t;

    vec_t tv[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int gap);
        start_cyc = cyc;
        midi_rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            midi_rx = b[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        midi_rx = stop_bit;
        repeat (BIT_CLKS) @(negedge clk);
        midi_rx = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic check_outputs(input string tag, input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
        check({tag, " byte0"}, midi_byte0, e0);
        check({tag, " byte1"}, midi_byte1, e1);
        check({tag, " byte2"}, midi_byte2, e2);
    endtask

    initial begin
        int s0;
        int f0;

        tv[0] = '{seq: {8'h90, 8'h3C, 8'h64, 8'h00, 8'h00, 8'h00}, n: 3, strobes: 1, e0: 8'h90, e1: 8'h3C, e2: 8'h64};
        tv[1] = '{seq: {8'h3E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, n: 2, strobes: 1, e0: 8'h90, e1: 8'h3E, e2: 8'h00};
        tv[2] = '{seq: {8'hC0, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00}, n: 2, strobes: 1, e0: 8'hC0, e1: 8'h05, e2: 8'h00};
        tv[3] = '{seq: {8'hF0, 8'h7E, 8'h01, 8'hF7, 8'h40, 8'h00}, n: 5, strobes: 0, e0: 8'hC0, e1: 8'h05, e2: 8'h00};
        tv[4] = '{seq: {8'h90, 8'hF8, 8'h3C, 8'hFE, 8'h64, 8'h00}, n: 5, strobes: 1, e0: 8'h90, e1: 8'h3C, e2: 8'h64};
        tv[5] = '{seq: {8'h90, 8'h3C, 8'h80, 8'h3C, 8'h40, 8'h00}, n: 5, strobes: 1, e0: 8'h80, e1: 8'h3C, e2: 8'h40};
        tv[6] = '{seq: {8'hD1, 8'h20, 8'h21, 8'h00, 8'h00, 8'h00}, n: 3, strobes: 2, e0: 8'hD1, e1: 8'h21, e2: 8'h00};
        tv[7] = '{seq: {8'hF0, 8'hF8, 8'h40, 8'h00, 8'h00, 8'h00}, n: 3, strobes: 0, e0: 8'hD1, e1: 8'h21, e2: 8'h00};
        tv[8] = '{seq: {8'h95, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00}, n: 3, strobes: 1, e0: 8'h95, e1: 8'h3C, e2: 8'h00};

        // Reset state
        reset   = 1'b0;
        midi_rx = 1'b1;
        repeat (5) @(negedge clk);
        check("reset ready", midi_byte_ready, 0);
        check("reset ferr", framing_error, 0);
        check_outputs("reset", 8'h00, 8'h00, 8'h00);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check("post-reset strobes", n_strobe, 0);
        check_outputs("post-reset", 8'h00, 8'h00, 8'h00);

        // Table-driven messages
        for (int r = 0; r < 9; r++) begin
            s0 = n_strobe;
            f0 = n_fe;
            for (int k = 0; k < tv[r].n; k++)
                send_byte(tv[r].seq[k], 1'b1, 8);
            repeat (20) @(negedge clk);
            check($sformatf("row%0d strobes", r), n_strobe - s0, tv[r].strobes);
            check($sformatf("row%0d ferr", r), n_fe - f0, 0);
            check_outputs($sformatf("row%0d", r), tv[r].e0, tv[r].e1, tv[r].e2);
            if (tv[r].strobes > 0)
                check($sformatf("row%0d latency", r), last_strobe_cyc - start_cyc, LATENCY);
        end

        // Framing error on 0x3C, then resend
        s0 = n_strobe;
        f0 = n_fe;
        send_byte(8'h90, 1'b1, 8);
        send_byte(8'h3C, 1'b0, 40);
        check("frame err count", n_fe - f0, 1);
        check("frame err strobes", n_strobe - s0, 0);
        send_byte(8'h3C, 1'b1, 8);
        send_byte(8'h64, 1'b1, 20);
        check("frame resend strobes", n_strobe - s0, 1);
        check_outputs("frame resend", 8'h90, 8'h3C, 8'h64);

        // Quarter-bit glitch on idle line, then a running-status message
        s0 = n_strobe;
        f0 = n_fe;
        midi_rx = 1'b0;
        repeat (BIT_CLKS / 4) @(negedge clk);
        midi_rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch ferr", n_fe - f0, 0);
        check("glitch strobes", n_strobe - s0, 0);
        send_byte(8'h3D, 1'b1, 8);
        send_byte(8'h65, 1'b1, 20);
        check("post-glitch strobes", n_strobe - s0, 1);
        check_outputs("post-glitch", 8'h90, 8'h3D, 8'h65);

        // Reset in the middle of a data byte
        send_byte(8'h90, 1'b1, 8);
        midi_rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            midi_rx = (i == 2);
            repeat (BIT_CLKS) @(negedge clk);
        end
        reset = 1'b0;
        #1;
        check("midreset ready", midi_byte_ready, 0);
        check_outputs("midreset", 8'h00, 8'h00, 8'h00);
        midi_rx = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        s0 = n_strobe;
        send_byte(8'h3C, 1'b1, 8);
        send_byte(8'h64, 1'b1, 20);
        check("no rs strobes", n_strobe - s0, 0);
        check_outputs("no rs", 8'h00, 8'h00, 8'h00);
        send_byte(8'h80, 1'b1, 8);
        send_byte(8'h3C, 1'b1, 8);
        send_byte(8'h40, 1'b1, 20);
        check("after reset strobes", n_strobe - s0, 1);
        check_outputs("after reset", 8'h80, 8'h3C, 8'h40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
